// File: rtl/seq_counter_ctl.sv
// Sequence counter and timing generator for the basic-computer control unit.
// Holds SC, decodes it to the one-hot T bus and ends each cycle at a per-opcode step.
module seq_counter_ctl #(
  parameter int SC_WIDTH = 4,
  parameter int NUM_OPS = 8,
  parameter logic [NUM_OPS*SC_WIDTH-1:0] END_T =
    {4'd3, 4'd6, 4'd5, 4'd4, 4'd4, 4'd5, 4'd5, 4'd5},
  parameter int INT_END_T = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     halt_i,
  input  logic                     stall_i,
  input  logic                     r_i,
  input  logic [NUM_OPS-1:0]       d_i,
  output logic [SC_WIDTH-1:0]      sc_o,
  output logic [2**SC_WIDTH-1:0]   t_o,
  output logic                     clr_o,
  output logic                     inc_o,
  output logic                     run_o,
  output logic                     cycle_done_o,
  output logic                     err_o
);

  localparam int NT = 2**SC_WIDTH;
  localparam logic [SC_WIDTH-1:0] IntEnd = SC_WIDTH'(INT_END_T);
  localparam logic [SC_WIDTH-1:0] DecodeEnd = SC_WIDTH'(3);
  localparam logic [SC_WIDTH-1:0] ScMax = '1;
  localparam logic [NT-1:0] TOne = NT'(1);

  logic [SC_WIDTH-1:0] sc_q, sc_d;
  logic                run_q, run_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic opEnd;
  logic cycleEnd;
  logic illegalOp;

  // Opcode bits are only trusted once decode (T2) has finished.
  always_comb begin
    opEnd = 1'b0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (d_i[k] && (sc_q == END_T[k*SC_WIDTH +: SC_WIDTH])) begin
        opEnd = 1'b1;
      end
    end
  end

  assign cycleEnd  = r_i ? (sc_q == IntEnd) : ((sc_q >= DecodeEnd) && opEnd);
  assign clr_o     = run_q & ~stall_i & cycleEnd;
  assign inc_o     = run_q & ~stall_i & ~cycleEnd;
  assign illegalOp = run_q && !r_i && (sc_q == DecodeEnd) && ($countones(d_i) != 1);

  always_comb begin
    sc_d   = sc_q;
    run_d  = run_q;
    done_d = clr_o;
    err_d  = err_q;
    if (clr_o) begin
      sc_d = '0;
    end else if (inc_o) begin
      sc_d = sc_q + 1'b1;
    end
    if (halt_i) begin
      run_d = 1'b0;
    end else if (start_i) begin
      run_d = 1'b1;
    end
    if (illegalOp || (inc_o && (sc_q == ScMax))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sc_q   <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sc_q   <= sc_d;
      run_q  <= run_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign sc_o         = sc_q;
  assign t_o          = TOne << sc_q;
  assign run_o        = run_q;
  assign cycle_done_o = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_seq_counter_ctl.sv
// Scoreboard bench for seq_counter_ctl: directed vectors push hand-computed
// expectations, an independent monitor pops and compares them.
module tb_seq_counter_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, stall, r;
  logic [7:0]  d;
  logic [3:0]  sc;
  logic [15:0] t;
  logic        clr, inc, run, cycleDone, err;

  typedef struct packed {
    logic [3:0] sc;
    logic       clr;
    logic       inc;
    logic       run;
    logic       done;
    logic       err;
  } expect_t;

  expect_t expQ[$];
  string   tagQ[$];
  int      numCompared = 0;
  int      numMismatched = 0;
  event    sampleNow;

  seq_counter_ctl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .halt_i       (halt),
    .stall_i      (stall),
    .r_i          (r),
    .d_i          (d),
    .sc_o         (sc),
    .t_o          (t),
    .clr_o        (clr),
    .inc_o        (inc),
    .run_o        (run),
    .cycle_done_o (cycleDone),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExpect(input string tag, input logic [3:0] eSc,
                            input logic eClr, input logic eInc, input logic eRun,
                            input logic eDone, input logic eErr);
    expect_t e;
    e.sc   = eSc;
    e.clr  = eClr;
    e.inc  = eInc;
    e.run  = eRun;
    e.done = eDone;
    e.err  = eErr;
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  // Drive one cycle of inputs just after the edge and queue what the DUT should show.
  task automatic applyStimulus(input string tag, input logic iStart, input logic iHalt,
                               input logic iStall, input logic iR, input logic [7:0] iD,
                               input logic [3:0] eSc, input logic eClr, input logic eInc,
                               input logic eRun, input logic eDone, input logic eErr);
    @(posedge clk);
    #1;
    start = iStart;
    halt  = iHalt;
    stall = iStall;
    r     = iR;
    d     = iD;
    pushExpect(tag, eSc, eClr, eInc, eRun, eDone, eErr);
  endtask

  task automatic checkOutput(input string tag, input expect_t e);
    logic [15:0] expT;
    logic [24:0] act, req;
    expT = 16'(1) << e.sc;
    act = {sc, t, clr, inc, run, cycleDone, err};
    req = {e.sc, expT, e.clr, e.inc, e.run, e.done, e.err};
    numCompared++;
    if (act !== req) begin
      numMismatched++;
      $display("[TB] FAIL %s: got sc=%0d t=%h clr=%b inc=%b run=%b done=%b err=%b, want sc=%0d t=%h clr=%b inc=%b run=%b done=%b err=%b",
               tag, sc, t, clr, inc, run, cycleDone, err,
               e.sc, expT, e.clr, e.inc, e.run, e.done, e.err);
    end
  endtask

  // Monitor: samples mid-cycle, or on demand when an async event must be seen before the edge.
  initial begin
    expect_t e;
    string   tag;
    forever begin
      @(negedge clk or sampleNow);
      if (expQ.size() > 0) begin
        e   = expQ.pop_front();
        tag = tagQ.pop_front();
        checkOutput(tag, e);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    halt  = 1'b0;
    stall = 1'b0;
    r     = 1'b0;
    d     = 8'h00;

    applyStimulus("reset", 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    applyStimulus("reset", 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // LDA: ends at T5
    applyStimulus("lda_start", 1, 0, 0, 0, 8'h04, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      applyStimulus("lda_count", 0, 0, 0, 0, 8'h04, 4'(i), 0, 1, 1, 0, 0);
    applyStimulus("lda_end", 0, 0, 0, 0, 8'h04, 5, 1, 0, 1, 0, 0);

    // BUN: ends at T4
    applyStimulus("bun_done", 0, 0, 0, 0, 8'h10, 0, 0, 1, 1, 1, 0);
    for (int i = 1; i < 4; i++)
      applyStimulus("bun_count", 0, 0, 0, 0, 8'h10, 4'(i), 0, 1, 1, 0, 0);
    applyStimulus("bun_end", 0, 0, 0, 0, 8'h10, 4, 1, 0, 1, 0, 0);

    // ISZ: ends at T6
    applyStimulus("isz_done", 0, 0, 0, 0, 8'h40, 0, 0, 1, 1, 1, 0);
    for (int i = 1; i < 6; i++)
      applyStimulus("isz_count", 0, 0, 0, 0, 8'h40, 4'(i), 0, 1, 1, 0, 0);
    applyStimulus("isz_end", 0, 0, 0, 0, 8'h40, 6, 1, 0, 1, 0, 0);

    // Interrupt cycle ignores D and ends at T2
    applyStimulus("intr_done", 0, 0, 0, 1, 8'h40, 0, 0, 1, 1, 1, 0);
    applyStimulus("intr_count", 0, 0, 0, 1, 8'h40, 1, 0, 1, 1, 0, 0);
    applyStimulus("intr_end", 0, 0, 0, 1, 8'h40, 2, 1, 0, 1, 0, 0);

    // Memory-wait stall at T4 of AND
    applyStimulus("stall_done", 0, 0, 0, 0, 8'h01, 0, 0, 1, 1, 1, 0);
    for (int i = 1; i < 4; i++)
      applyStimulus("stall_count", 0, 0, 0, 0, 8'h01, 4'(i), 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("stall_hold", 0, 0, 1, 0, 8'h01, 4, 0, 0, 1, 0, 0);
    applyStimulus("stall_release", 0, 0, 0, 0, 8'h01, 4, 0, 1, 1, 0, 0);
    applyStimulus("stall_end", 0, 0, 0, 0, 8'h01, 5, 1, 0, 1, 0, 0);

    // HALT wins over START; the in-flight increment still lands
    applyStimulus("halt_done", 0, 0, 0, 0, 8'h01, 0, 0, 1, 1, 1, 0);
    applyStimulus("halt_count", 0, 0, 0, 0, 8'h01, 1, 0, 1, 1, 0, 0);
    applyStimulus("halt_count", 0, 0, 0, 0, 8'h01, 2, 0, 1, 1, 0, 0);
    applyStimulus("halt_edge", 1, 1, 0, 0, 8'h01, 3, 0, 1, 1, 0, 0);
    applyStimulus("halt_frozen", 0, 0, 0, 0, 8'h01, 4, 0, 0, 0, 0, 0);
    applyStimulus("halt_frozen", 0, 0, 0, 0, 8'h01, 4, 0, 0, 0, 0, 0);
    applyStimulus("resume_start", 1, 0, 0, 0, 8'h01, 4, 0, 0, 0, 0, 0);
    applyStimulus("resume_count", 0, 0, 0, 0, 8'h01, 4, 0, 1, 1, 0, 0);
    applyStimulus("resume_end", 0, 0, 0, 0, 8'h01, 5, 1, 0, 1, 0, 0);

    // Async reset while SC=5, observed before the next clock edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    pushExpect("async_reset", 0, 0, 0, 0, 0, 0);
    -> sampleNow;
    applyStimulus("reset_hold", 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Illegal opcode and runaway wrap
    applyStimulus("run_start", 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus("runaway_pre", 0, 0, 0, 0, 8'h00, 4'(i), 0, 1, 1, 0, 0);
    for (int i = 4; i < 16; i++)
      applyStimulus("runaway_err", 0, 0, 0, 0, 8'h00, 4'(i), 0, 1, 1, 0, 1);
    applyStimulus("wrap_nodone", 0, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 1);
    applyStimulus("err_sticky", 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1);
    applyStimulus("err_sticky", 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1);

    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    pushExpect("err_clear", 0, 0, 0, 0, 0, 0);
    -> sampleNow;

    for (int i = 0; i < 20 && expQ.size() > 0; i++)
      @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      numMismatched++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/seq_counter_ctl.md
Name: seq_counter_ctl

Overview:
Parametrised sequence counter and timing generator for the basic-computer control unit. It holds the SC register and decodes it to a one-hot T bus. It ends each instruction or interrupt cycle at a per-opcode programmable timing step. It adds run/halt control, memory-wait stall, cycle-done pulses and a runaway-count error flag.

Parameters:
SC_WIDTH, 4, counter width; number of timing states NT = 2**SC_WIDTH.
NUM_OPS, 8, width of decoded-opcode bus D.
END_T, {3,6,5,4,4,5,5,5} packed NUM_OPS*SC_WIDTH bits, final timing step per opcode. Field k is bits [k*SC_WIDTH +: SC_WIDTH] and is the end step for D[k]. With the default packing this gives D0..D2=5, D3=4, D4=4, D5=5, D6=6, D7=3.
INT_END_T, 2, final timing step of the interrupt cycle.

Ports:
CLK  in  1  system clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
START  in  1  sets run flip-flop S.
HALT  in  1  clears S (HLT executed).
STALL  in  1  hold SC this cycle (memory wait).
R  in  1  interrupt-cycle flag.
D  in  NUM_OPS  one-hot decoded opcode, valid from T2 onward.
SC  out  SC_WIDTH  current count.
T  out  NT  one-hot decode of SC.
CLR  out  1  SC clears at next edge.
INC  out  1  SC increments at next edge.
RUN  out  1  S flip-flop.
CYCLE_DONE  out  1  registered 1-cycle pulse after SC clears by end condition.
ERR  out  1  sticky runaway/illegal-opcode flag.

Behaviour:
- Reset (async, RST_N=0): SC=0, so T=1 (T[0]). RUN=0, CYCLE_DONE=0, ERR=0. CLR and INC are 0 because RUN=0. A reset mid-instruction aborts the instruction immediately.
- The run flip-flop updates on each edge:
  - HALT=1: RUN becomes 0. HALT takes priority over START.
  - START=1 and HALT=0: RUN becomes 1.
  - The first active count happens on the edge after RUN rises.
- End condition END, combinational:
  - R=1: END = (SC == INT_END_T). D is ignored.
  - R=0: END = (SC >= 3) and OR over k of (D[k] and SC == END_T field k).
  - D is ignored while SC < 3 (fetch T0, T1; decode T2).
- Outputs:
  - CLR = RUN & ~STALL & END.
  - INC = RUN & ~STALL & ~END.
  - CLR and INC are never both 1. Both are 0 when RUN=0 or STALL=1.
- SC next state:
  - CLR: SC becomes 0.
  - INC: SC becomes SC+1, modulo NT.
  - Otherwise SC holds.
- HALT in the same cycle as a CLR/INC: the count update still happens on that edge, and RUN drops on that edge. SC then freezes at its new value until START.
- Wrap: INC at SC = NT-1 sets SC to 0 and sets ERR. CYCLE_DONE is not pulsed on a wrap.
- Illegal opcode: ERR is set in the cycle where all of the following hold:
  - SC == 3, R=0, RUN=1;
  - D is not one-hot (popcount != 1).
  - Counting continues regardless of the error.
- ERR is sticky and clears only on reset.
- CYCLE_DONE is 1 for exactly the one cycle following a CLR edge. T[0] is asserted in the same cycle.
- T is a pure decode of SC: exactly one bit high at all times, including during reset.
- SC_WIDTH must satisfy 2**SC_WIDTH > every END_T field and > INT_END_T. This is a configuration rule, not checked in RTL.

Test Plan:
- Reset, START pulse, D=8'h04 (LDA), R=0: SC steps 0,1,2,3,4,5,0. CLR=1 only at SC=5. CYCLE_DONE high at the following SC=0. T one-hot throughout.
- D=8'h10 (BUN) then D=8'h40 (ISZ), back to back: CLR at SC=4, then CLR at SC=6. Instruction lengths are 5 and 7 cycles.
- R=1 with D=8'h40: CLR at SC=2, giving a 3-cycle interrupt cycle.
- STALL high for 3 cycles at SC=4 with D=8'h01: SC holds at 4 and CLR=INC=0 throughout the stall. After the stall, SC goes 5 then 0.
- HALT asserted at SC=3 with START also high: RUN=0 next cycle and SC frozen at 4. START alone resumes at 5. Async reset while SC=5 gives SC=0 immediately.
- D=8'h00 with R=0: ERR set at SC=3 and SC runs 0..15. Wrap to 0 with no CYCLE_DONE. ERR stays 1 until RST_N is asserted low.
